// File: rtl/acc_proc_core.sv
// acc_proc_core: parametrised multicycle accumulator core with req/ack data port.
// Define ACC_MUL_EN to build the opcode-7 multiplier; otherwise opcode 7 is a NOP.
module acc_proc_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREG   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        status,
  output logic              im_en,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [15:0]       im_rdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  output logic [ADDR_W-1:0] pc_out,
  output logic              end_process
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_HALT, S_HOST
  } state_t;

  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVR  = 4'h3;
  localparam logic [3:0] OP_MVAC = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_JPZ  = 4'h9;
  localparam logic [3:0] OP_JPNZ = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_SDAR = 4'hC;
  localparam logic [3:0] OP_INCD = 4'hD;
  localparam logic [3:0] OP_END  = 4'hF;
  localparam logic [4:0] NREG_L  = 5'(NREG);

  state_t            r_state;
  state_t            w_nstate;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_dar;
  logic [DATA_W-1:0] r_ac;
  logic [15:0]       r_ir;
  logic              r_z;
  logic [DATA_W-1:0] r_regs [16];
  logic              r_hret;
  logic              r_hwr;
  logic              r_hused;
  logic [ADDR_W-1:0] r_haddr;
  logic [DATA_W-1:0] r_hwdata;
  logic [DATA_W-1:0] r_hrdata;
  logic              r_hdone;

  logic [3:0]        w_op;
  logic [3:0]        w_idx;
  logic [7:0]        w_imm;
  logic              w_ivld;
  logic              w_run;
  logic              w_hreq;
  logic [DATA_W-1:0] w_rval;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_dif;
  logic [DATA_W-1:0] w_inc;

  assign w_op   = r_ir[15:12];
  assign w_idx  = r_ir[11:8];
  assign w_imm  = r_ir[7:0];
  assign w_ivld = {1'b0, w_idx} < NREG_L;
  assign w_run  = (status == 2'b01);
  assign w_hreq = status[1] & ~r_hused;
  assign w_rval = w_ivld ? r_regs[w_idx] : '0;
  assign w_sum  = r_ac + w_rval;
  assign w_dif  = r_ac - w_rval;
  assign w_inc  = w_rval + DATA_W'(1);

`ifdef ACC_MUL_EN
  logic [DATA_W-1:0] w_mul;
  assign w_mul = r_ac * w_rval;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_run)       w_nstate = S_FETCH;
        else if (w_hreq) w_nstate = S_HOST;
      end
      S_FETCH:  w_nstate = w_run ? S_DECODE : S_IDLE;
      S_DECODE: w_nstate = w_run ? S_EXEC : S_IDLE;
      S_EXEC: begin
        unique case (1'b1)
          (w_op == OP_LDAC),
          (w_op == OP_STAC): w_nstate = S_MEM;
          (w_op == OP_END):  w_nstate = S_HALT;
          default:           w_nstate = w_run ? S_FETCH : S_IDLE;
        endcase
      end
      S_MEM:  if (dm_ack) w_nstate = w_run ? S_FETCH : S_IDLE;
      S_HALT: if (w_hreq) w_nstate = S_HOST;
      S_HOST: if (dm_ack) w_nstate = r_hret ? S_HALT : S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    im_en       = 1'b0;
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    dm_addr     = '0;
    dm_wdata    = '0;
    end_process = 1'b0;
    unique case (r_state)
      S_FETCH: im_en = 1'b1;
      S_MEM: begin
        dm_req   = 1'b1;
        dm_we    = (w_op == OP_STAC);
        dm_addr  = r_dar;
        dm_wdata = r_ac;
      end
      S_HOST: begin
        dm_req   = 1'b1;
        dm_we    = r_hwr;
        dm_addr  = r_haddr;
        dm_wdata = r_hwdata;
      end
      S_HALT:  end_process = 1'b1;
      default: ;
    endcase
  end

  assign im_addr    = r_pc;
  assign pc_out     = r_pc;
  assign host_rdata = r_hrdata;
  assign host_done  = r_hdone;

  // Host fields are latched at request so they stay stable while dm_req is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_dar    <= '0;
      r_ac     <= '0;
      r_ir     <= '0;
      r_z      <= 1'b0;
      r_hret   <= 1'b0;
      r_hwr    <= 1'b0;
      r_hused  <= 1'b0;
      r_haddr  <= '0;
      r_hwdata <= '0;
      r_hrdata <= '0;
      r_hdone  <= 1'b0;
      for (int k = 0; k < 16; k++) r_regs[k] <= '0;
    end else begin
      r_hdone <= 1'b0;
      if (status == 2'b00) r_hused <= 1'b0;
      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (w_nstate == S_HOST) begin
            r_hret   <= (r_state == S_HALT);
            r_hwr    <= ~status[0];
            r_haddr  <= host_addr;
            r_hwdata <= host_wdata;
          end
        end
        S_DECODE: begin
          if (w_run) begin
            r_ir <= im_rdata;
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        S_EXEC: begin
          unique case (w_op)
            OP_MVR:  if (w_ivld) r_regs[w_idx] <= r_ac;
            OP_MVAC: r_ac <= w_rval;
            OP_ADD: begin
              r_ac <= w_sum;
              r_z  <= (w_sum == '0);
            end
            OP_SUB: begin
              r_ac <= w_dif;
              r_z  <= (w_dif == '0);
            end
            OP_MUL: begin
`ifdef ACC_MUL_EN
              r_ac <= w_mul;
              r_z  <= (w_mul == '0);
`endif
            end
            OP_INC: begin
              if (w_ivld) r_regs[w_idx] <= w_inc;
              r_z <= (w_inc == '0);
            end
            OP_JPZ:  if (r_z) r_pc <= ADDR_W'(w_imm);
            OP_JPNZ: if (!r_z) r_pc <= ADDR_W'(w_imm);
            OP_LDI:  r_ac <= DATA_W'(w_imm);
            OP_SDAR: r_dar <= ADDR_W'(r_ac);
            OP_INCD: r_dar <= r_dar + ADDR_W'(1);
            default: ;
          endcase
        end
        S_MEM: begin
          if (dm_ack && w_op == OP_LDAC) r_ac <= dm_rdata;
        end
        S_HOST: begin
          if (dm_ack) begin
            r_hused <= 1'b1;
            r_hdone <= 1'b1;
            if (!r_hwr) r_hrdata <= dm_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_proc_core.sv
// tb_acc_proc_core: vector table, corner sequences and random programs
// checked against an instruction-level model of the accumulator core.
module tb_acc_proc_core;

`ifdef ACC_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif
  localparam int NREG = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  status = 2'b00;
  logic        im_en;
  logic [15:0] im_addr;
  logic [15:0] im_rdata = 16'h0;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata = 16'h0;
  logic        dm_ack = 1'b0;
  logic [15:0] host_addr = 16'h0;
  logic [15:0] host_wdata = 16'h0;
  logic [15:0] host_rdata;
  logic        host_done;
  logic [15:0] pc_out;
  logic        end_process;

  always #5 clk = ~clk;

  acc_proc_core dut (
    .clk(clk), .rst_n(rst_n), .status(status),
    .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_done(host_done),
    .pc_out(pc_out), .end_process(end_process)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] rom  [256];
  logic [15:0] dmem [65536];
  logic [15:0] mdm  [65536];
  int ack_dly = 0;
  bit rnd_dly = 1'b0;
  int cnt = 0;
  logic [32:0] act_q [$];
  logic [32:0] exp_q [$];

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  ri;
    logic [15:0] a;
    logic [15:0] r;
    logic [15:0] eac;
    logic        ez;
  } vec_t;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ROM and data RAM responders, driven away from the rising edge
  always @(negedge clk) begin
    if (im_en) im_rdata = rom[im_addr[7:0]];
    if (dm_ack) begin
      dm_ack = 1'b0;
      cnt = 0;
    end else if (dm_req) begin
      if (cnt >= ack_dly) begin
        dm_ack = 1'b1;
        cnt = 0;
        if (dm_we) dmem[dm_addr] = dm_wdata;
        else dm_rdata = dmem[dm_addr];
        act_q.push_back({dm_we, dm_addr, dm_wdata});
        if (rnd_dly) ack_dly = $urandom_range(0, 3);
      end else cnt++;
    end else cnt = 0;
  end

  task automatic load_end();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    status = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int maxc, input bit pz);
    int n = 0;
    status = 2'b01;
    while (!end_process && n < maxc) begin
      @(posedge clk); #1;
      n++;
      if (pz) status = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b01;
    end
    status = 2'b00;
    chk("halt reached", 40'(end_process), 40'd1);
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!dm_req && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req seen", 40'(dm_req), 40'd1);
  endtask

  // instruction-level reference: runs the ROM program to END
  task automatic model_run(output logic [15:0] epc);
    logic [15:0] pc, ac, dar, ins, rv;
    logic [15:0] r [16];
    logic [3:0]  i;
    bit z, iv;
    pc = 0; ac = 0; dar = 0; z = 0;
    for (int k = 0; k < 16; k++) r[k] = 0;
    exp_q.delete();
    for (int s = 0; s < 1000; s++) begin
      ins = rom[pc[7:0]];
      pc = pc + 16'd1;
      i = ins[11:8];
      iv = (int'(i) < NREG);
      rv = iv ? r[i] : 16'h0;
      case (ins[15:12])
        4'h1: begin ac = mdm[dar]; exp_q.push_back({1'b0, dar, 16'h0}); end
        4'h2: begin mdm[dar] = ac; exp_q.push_back({1'b1, dar, ac}); end
        4'h3: if (iv) r[i] = ac;
        4'h4: ac = rv;
        4'h5: begin ac = ac + rv; z = (ac == 0); end
        4'h6: begin ac = ac - rv; z = (ac == 0); end
        4'h7: if (MULEN) begin ac = ac * rv; z = (ac == 0); end
        4'h8: begin rv = rv + 16'd1; if (iv) r[i] = rv; z = (rv == 0); end
        4'h9: if (z) pc = {8'h0, ins[7:0]};
        4'hA: if (!z) pc = {8'h0, ins[7:0]};
        4'hB: ac = {8'h0, ins[7:0]};
        4'hC: dar = ac;
        4'hD: dar = dar + 16'd1;
        4'hF: break;
        default: ;
      endcase
    end
    epc = pc;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv [16];
    logic [15:0] s_addr, s_wd, epc;
    logic s_we, prev;
    bit stable, saw;
    int n, nd, nr;
    logic [32:0] a;

    for (int i = 0; i < 65536; i++) dmem[i] = 16'($urandom);
    tv[0]  = '{4'h6, 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    tv[1]  = '{4'h5, 4'h1, 16'h0003, 16'h0005, 16'h0008, 1'b0};
    tv[2]  = '{4'h5, 4'h2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tv[3]  = '{4'h6, 4'h3, 16'h1234, 16'h1234, 16'h0000, 1'b1};
    tv[4]  = '{4'h7, 4'h1, 16'h0300, 16'h0100, MULEN ? 16'h0000 : 16'h0300, MULEN};
    tv[5]  = '{4'h7, 4'h4, 16'h0012, 16'h0034, MULEN ? 16'h03A8 : 16'h0012, 1'b0};
    tv[6]  = '{4'h7, 4'h5, 16'hFFFF, 16'hFFFF, MULEN ? 16'h0001 : 16'hFFFF, 1'b0};
    tv[7]  = '{4'h8, 4'h2, 16'h0007, 16'h0000, 16'h0007, 1'b0};
    tv[8]  = '{4'h8, 4'h0, 16'h0009, 16'hFFFF, 16'h0009, 1'b1};
    tv[9]  = '{4'h4, 4'h1, 16'h0001, 16'hABCD, 16'hABCD, 1'b0};
    tv[10] = '{4'h4, 4'h6, 16'h0001, 16'hABCD, 16'h0000, 1'b0};
    tv[11] = '{4'h4, 4'h5, 16'h0001, 16'hABCD, 16'hABCD, 1'b0};
    tv[12] = '{4'h5, 4'hF, 16'h0055, 16'h0099, 16'h0055, 1'b0};
    tv[13] = '{4'h0, 4'h1, 16'h4321, 16'h0001, 16'h4321, 1'b0};
    tv[14] = '{4'hE, 4'h1, 16'h4321, 16'h0001, 16'h4321, 1'b0};
    tv[15] = '{4'h6, 4'h6, 16'h0000, 16'h0077, 16'h0000, 1'b1};

    // reset state with run requested
    load_end();
    rst_n = 1'b0;
    status = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl", 40'({im_en, dm_req, dm_we, host_done, end_process}), 40'd0);
    chk("reset addr", 40'({im_addr, dm_addr}), 40'd0);
    chk("reset data", 40'({dm_wdata, host_rdata}), 40'd0);
    chk("reset pc", 40'(pc_out), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first fetch", 40'(im_en), 40'd1);
    chk("first addr", 40'(im_addr), 40'd0);

    // vector table: operands loaded from RAM, result stored, Z seen via JPZ
    rnd_dly = 1'b0;
    ack_dly = 0;
    for (int v = 0; v < 16; v++) begin
      load_end();
      rom[0] = 16'hB041; rom[1] = 16'hC000; rom[2] = 16'h1000;
      rom[3] = {4'h3, tv[v].ri, 8'h00};
      rom[4] = 16'hB040; rom[5] = 16'hC000; rom[6] = 16'h1000;
      rom[7] = {tv[v].op, tv[v].ri, 8'h00};
      rom[8] = 16'h2000; rom[9] = 16'h9030;
      dmem[16'h0040] = tv[v].a;
      dmem[16'h0041] = tv[v].r;
      do_reset();
      run_to_halt(200, 1'b0);
      chk($sformatf("vec%0d ac", v), 40'(dmem[16'h0040]), 40'(tv[v].eac));
      chk($sformatf("vec%0d pc", v), 40'(pc_out), tv[v].ez ? 40'h31 : 40'd11);
    end

    // STAC with 5 wait cycles: request fields must hold
    load_end();
    rom[0] = 16'hB040; rom[1] = 16'hC000; rom[2] = 16'hB077;
    rom[3] = 16'h2000; rom[4] = 16'h0000;
    ack_dly = 5;
    do_reset();
    status = 2'b01;
    wait_req(40);
    s_addr = dm_addr; s_wd = dm_wdata; s_we = dm_we;
    stable = 1'b1;
    n = 0;
    while (dm_req && n < 20) begin
      if (dm_addr !== s_addr || dm_wdata !== s_wd || dm_we !== s_we) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("stall stable", 40'(stable), 40'd1);
    chk("stall req cycles", 40'(n), 40'd6);
    chk("fetch after ack", 40'(im_en), 40'd1);
    chk("stac fields", 40'({s_we, s_addr, s_wd}), {7'd0, 1'b1, 16'h0040, 16'h0077});
    chk("stac ram", 40'(dmem[16'h0040]), 40'h77);

    // pause while stalled in MEM
    load_end();
    rom[0] = 16'hB040; rom[1] = 16'hC000; rom[2] = 16'h1000; rom[3] = 16'h0000;
    ack_dly = 4;
    do_reset();
    status = 2'b01;
    wait_req(40);
    status = 2'b00;
    n = 0;
    while (dm_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pause req cycles", 40'(n), 40'd5);
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (im_en || end_process) saw = 1'b1;
    end
    chk("pause idle", 40'(saw), 40'd0);
    chk("pause pc", 40'(pc_out), 40'd3);
    status = 2'b01;
    @(posedge clk); #1;
    chk("resume fetch", 40'({im_en, im_addr}), {23'd0, 1'b1, 16'd3});
    run_to_halt(100, 1'b0);
    chk("resume end pc", 40'(pc_out), 40'd5);

    // reset during a pending request
    load_end();
    rom[0] = 16'hB040; rom[1] = 16'hC000; rom[2] = 16'h2000;
    ack_dly = 1000;
    do_reset();
    status = 2'b01;
    wait_req(40);
    #2 rst_n = 1'b0;
    #1 chk("async abort", 40'(dm_req), 40'd0);
    ack_dly = 2;

    // host read then host write after END
    load_end();
    dmem[16'h0010] = 16'hBEEF;
    do_reset();
    run_to_halt(50, 1'b0);
    chk("end pc", 40'(pc_out), 40'd1);
    status = 2'b11;
    host_addr = 16'h0010;
    nd = 0; nr = 0; prev = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (host_done) nd++;
      if (dm_req && !prev) nr++;
      prev = dm_req;
    end
    chk("host rd done", 40'(nd), 40'd1);
    chk("host rd reqs", 40'(nr), 40'd1);
    chk("host rdata", 40'(host_rdata), 40'hBEEF);
    chk("host halt kept", 40'(end_process), 40'd1);
    status = 2'b00;
    @(posedge clk); #1;
    status = 2'b10;
    host_addr = 16'h0011;
    host_wdata = 16'h1234;
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (host_done) nd++;
    end
    chk("host wr done", 40'(nd), 40'd1);
    chk("host wr ram", 40'(dmem[16'h0011]), 40'h1234);
    status = 2'b00;

    // random straight-line programs with forward jumps and random pauses
    rnd_dly = 1'b1;
    for (int p = 0; p < 25; p++) begin
      load_end();
      for (int k = 0; k < 20; k++) begin
        logic [3:0] op, ri;
        logic [7:0] imm;
        op = 4'($urandom_range(0, 14));
        ri = 4'($urandom_range(0, 7));
        imm = 8'($urandom_range(0, 255));
        if (op == 4'h8) ri = 4'($urandom_range(0, NREG - 1));
        if (op == 4'h9 || op == 4'hA) imm = 8'(k + 1 + $urandom_range(0, 19 - k));
        rom[k] = {op, ri, imm};
      end
      rom[20] = 16'h2000;
      rom[21] = 16'h90F0;
      mdm = dmem;
      model_run(epc);
      do_reset();
      act_q.delete();
      run_to_halt(3000, 1'b1);
      chk($sformatf("rnd%0d pc", p), 40'(pc_out), 40'(epc));
      chk($sformatf("rnd%0d ntx", p), 40'(act_q.size()), 40'(exp_q.size()));
      for (int t = 0; t < act_q.size() && t < exp_q.size(); t++) begin
        a = act_q[t];
        if (!a[32]) a[15:0] = 16'h0;
        chk($sformatf("rnd%0d tx%0d", p, t), 40'(a), 40'(exp_q[t]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
